siso_shift_arbiter: RTL
=======================

SISO_SHIFT_ARBITER -- requirements
Module: siso_shift_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, frame length in bits (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port valid0  input  1  requester 0 has a frame to send.
REQ-005 SHALL have port data0  input  WIDTH  requester 0 frame; sampled on handshake.
REQ-006 SHALL have port ready0  output  1  requester 0 frame accepted this cycle when valid0 is also high.
REQ-007 SHALL have port valid1, data1, ready1, identical in width and meaning to valid0, data0 and ready0, for requester 1.
REQ-008 SHALL have port shift_en  input  1  advance enable; low stalls the serial stream.
REQ-009 SHALL have port data_out  output  1  serial bit, MSB first.
REQ-010 SHALL have port out_valid  output  1  data_out carries a valid bit this cycle.
REQ-011 SHALL have port grant_id  output  1  requester that owns the current frame.
REQ-012 SHALL have port busy  output  1  frame in progress (state SHIFT).
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when the last bit of a frame is presented.

Function
REQ-014 SHALL implement the FSM states IDLE and SHIFT, plus a WIDTH-bit shift register, a bit counter of width clog2(WIDTH), and a last_grant flag.
REQ-015 In IDLE with exactly one valid high, SHALL assert ready only for that requester, combinationally.
REQ-016 In IDLE with both valid high, SHALL assert ready for the requester that is NOT last_grant (round-robin); the other ready SHALL stay low.
REQ-017 In SHIFT, ready0 and ready1 SHALL be 0; a requester SHALL hold valid and data stable until its ready is high.
REQ-018 On handshake, SHALL load shift_reg with the granted data, clear bit_cnt, set grant_id and last_grant to the granted index, and enter SHIFT next cycle.
REQ-019 In SHIFT, data_out SHALL equal shift_reg[WIDTH-1] and out_valid SHALL equal shift_en.
REQ-020 In SHIFT with shift_en=1, each cycle SHALL shift shift_reg left by one (LSB filled with 0) and increment bit_cnt.
REQ-021 In SHIFT with shift_en=0, shift_reg and bit_cnt SHALL hold; out_valid=0; frame_done=0.
REQ-022 When in SHIFT with shift_en=1 and bit_cnt==WIDTH-1, SHALL pulse frame_done for that cycle and return to IDLE next cycle.
REQ-023 First bit SHALL appear 1 cycle after handshake; an unstalled frame SHALL occupy exactly WIDTH SHIFT cycles.
REQ-024 Minimum gap between frames SHALL be one IDLE cycle; no acceptance SHALL occur in the frame_done cycle.
REQ-025 In IDLE, data_out, out_valid, busy and frame_done SHALL be 0; grant_id SHALL hold its last value.
REQ-026 Changes in valid0 or valid1 during SHIFT SHALL not affect the current frame.

Reset
REQ-027 With reset high at a clock edge, SHALL enter IDLE and clear shift_reg, bit_cnt, grant_id and last_grant to 0, overriding any handshake that cycle.
REQ-028 While reset is high, ready0, ready1, out_valid, busy, frame_done and data_out SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no frame_done; on release, arbitration SHALL restart with requester 1 preferred on a tie.

Verification
REQ-030 Single requester: WIDTH=8, valid0 with data0=8'hB2, shift_en=1 -> ready0 for 1 cycle; data_out=1,0,1,1,0,0,1,0 on 8 consecutive cycles; frame_done on the 8th bit; grant_id=0.
REQ-031 Contention: both valid after reset, data0=8'h0F, data1=8'hF0 -> requester 1 served first (serial F0); after one IDLE cycle, requester 0 (serial 0F).
REQ-032 Stall: shift_en low for 3 cycles after the 2nd bit of 8'hA5 -> data_out holds the 3rd bit with out_valid=0; the frame completes in 11 SHIFT cycles with an unchanged bit sequence.
REQ-033 Mid-frame reset: reset at bit 4 of 8'hFF -> data_out=0 and busy=0 from the next cycle; no frame_done; a later frame on requester 0 is accepted normally.
REQ-034 Fairness: both requesters held valid continuously for 6 frames -> grant_id alternates 1,0,1,0,1,0; no ready is asserted while busy=1.

Source files
------------

// File: rtl/siso_shift_arbiter.sv
// -----------------------------------------------------------------------------
// siso_shift_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter that feeds a single serial shifter.
//   A granted requester's WIDTH-bit frame is loaded in parallel and then
//   streamed out MSB first, one bit per enabled cycle.
//
// Handshake (both requester ports):
//   valid<n> is raised by the requester and held, with data<n> stable, until
//   ready<n> is seen high in the same cycle. ready<n> is combinational and is
//   only ever high in IDLE, outside reset, for the single winning requester;
//   valid<n> && ready<n> at a rising edge is the transfer.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   valid0/data0/ready0   requester 0 frame handshake
//   valid1/data1/ready1   requester 1 frame handshake
//   shift_en              advance enable; low stalls the serial stream
//   data_out              serial bit, MSB first
//   out_valid             data_out carries a valid bit this cycle
//   grant_id              requester that owns the current/last frame
//   busy                  frame in progress; this is the FSM state (SHIFT=1)
//   frame_done            one-cycle pulse while the last bit is presented
// -----------------------------------------------------------------------------
module siso_shift_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid0,
  input  logic [WIDTH-1:0] data0,
  output logic             ready0,
  input  logic             valid1,
  input  logic [WIDTH-1:0] data1,
  output logic             ready1,
  input  logic             shift_en,
  output logic             data_out,
  output logic             out_valid,
  output logic             grant_id,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shift_reg;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_grant_id;
  logic             r_last_grant;

  logic w_ready0;
  logic w_ready1;
  logic w_load;
  logic w_sel;
  logic w_advance;
  logic w_data_out;
  logic w_out_valid;
  logic w_busy;
  logic w_frame_done;

  // Next-state and output decode. Every output is forced low while reset is
  // high so nothing leaks out before the registers are cleared.
  always_comb begin
    w_next_state = r_state;
    w_ready0     = 1'b0;
    w_ready1     = 1'b0;
    w_load       = 1'b0;
    w_sel        = 1'b0;
    w_advance    = 1'b0;
    w_data_out   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b0;
    w_frame_done = 1'b0;

    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          // On a tie the requester that did not win last time is served.
          w_ready0 = valid0 & (~valid1 | r_last_grant);
          w_ready1 = valid1 & (~valid0 | ~r_last_grant);
          w_load   = w_ready0 | w_ready1;
          w_sel    = w_ready1;
          if (w_load) begin
            w_next_state = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          w_busy       = 1'b1;
          w_data_out   = r_shift_reg[WIDTH-1];
          w_out_valid  = shift_en;
          w_advance    = shift_en;
          w_frame_done = shift_en && (r_bit_cnt == LAST_BIT);
          // Returning to IDLE after the last bit guarantees at least one
          // idle cycle between frames; no acceptance in the done cycle.
          if (w_frame_done) begin
            w_next_state = ST_IDLE;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shift_reg  <= '0;
      r_bit_cnt    <= '0;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_shift_reg  <= w_sel ? data1 : data0;
        r_bit_cnt    <= '0;
        r_grant_id   <= w_sel;
        r_last_grant <= w_sel;
      end else if (w_advance) begin
        r_shift_reg <= {r_shift_reg[WIDTH-2:0], 1'b0};
        r_bit_cnt   <= r_bit_cnt + CW'(1);
      end
    end
  end

  assign ready0     = w_ready0;
  assign ready1     = w_ready1;
  assign data_out   = w_data_out;
  assign out_valid  = w_out_valid;
  assign busy       = w_busy;
  assign frame_done = w_frame_done;
  assign grant_id   = reset ? 1'b0 : r_grant_id;

endmodule
